// File: rtl/gcn_pkg.sv
// ============================================================================
// gcn_pkg : shared state encoding and stage codes for the GCN stage sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

package gcn_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      TRANS  = 3'd1,
      COMB   = 3'd2,
      ARGMAX = 3'd3,
      DONE   = 3'd4,
      FLUSH  = 3'd5,
      ERROR  = 3'd6
   } seq_state_t;

   localparam logic [1:0] STAGE_NONE   = 2'd0;
   localparam logic [1:0] STAGE_TRANS  = 2'd1;
   localparam logic [1:0] STAGE_COMB   = 2'd2;
   localparam logic [1:0] STAGE_ARGMAX = 2'd3;

   function automatic logic stage_active(input seq_state_t s);
      return (s == TRANS) || (s == COMB) || (s == ARGMAX);
   endfunction

   function automatic logic [1:0] stage_code(input seq_state_t s);
      case (s)
         TRANS:   return STAGE_TRANS;
         COMB:    return STAGE_COMB;
         ARGMAX:  return STAGE_ARGMAX;
         default: return STAGE_NONE;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/gcn_stage_watchdog.sv
// ============================================================================
// gcn_stage_watchdog : per-stage cycle counter flagging expiry at TIMEOUT_CYCLES-1
// Revision: 1.0
// ============================================================================
`default_nettype none

module gcn_stage_watchdog #(
   parameter int TIMEOUT_CYCLES  = 1024,
   parameter int STAGE_CNT_WIDTH = $clog2(TIMEOUT_CYCLES)
) (
   input  logic clk,
   input  logic reset,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam logic [STAGE_CNT_WIDTH-1:0] C_LAST = STAGE_CNT_WIDTH'(TIMEOUT_CYCLES - 1);

   logic [STAGE_CNT_WIDTH-1:0] cnt_q;

   assign expired_o = (cnt_q == C_LAST);

   // Holds at the last value so the counter never wraps back into range.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (en_i && !expired_o) begin
         cnt_q <= cnt_q + STAGE_CNT_WIDTH'(1);
      end
   end

endmodule

`default_nettype wire

// File: rtl/gcn_stage_sequencer.sv
// ============================================================================
// gcn_stage_sequencer : schedules Transformation -> Combination -> Argmax,
// arbitrates the shared memory read port, and supervises each stage.
// Revision: 1.0
// ============================================================================
`default_nettype none

module gcn_stage_sequencer
   import gcn_pkg::*;
#(
   parameter int ADDR_WIDTH      = 8,
   parameter int TIMEOUT_CYCLES  = 1024,
   parameter int CYCLE_WIDTH     = 16,
   parameter int STAGE_CNT_WIDTH = $clog2(TIMEOUT_CYCLES)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   abort,
   input  logic                   done_trans,
   input  logic                   done_comb,
   input  logic                   done_argmax,
   output logic                   en_trans,
   output logic                   en_comb,
   output logic                   en_argmax,
   input  logic                   trans_rd_en,
   input  logic [ADDR_WIDTH-1:0]  trans_rd_addr,
   input  logic                   comb_rd_en,
   input  logic [ADDR_WIDTH-1:0]  comb_rd_addr,
   output logic                   mem_rd_en,
   output logic [ADDR_WIDTH-1:0]  mem_rd_addr,
   output logic                   busy,
   output logic                   done,
   output logic                   error,
   output logic [1:0]             error_stage,
   output logic [CYCLE_WIDTH-1:0] cycle_count
);

   seq_state_t             state_q, state_d;
   logic [1:0]             error_stage_q, error_stage_d;
   logic                   en_trans_q, en_comb_q, en_argmax_q;
   logic                   busy_q, done_q, error_q;
   logic [CYCLE_WIDTH-1:0] cycle_q;
   logic                   wd_expired;
   logic                   wd_clr;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = TRANS;
         TRANS:   if (abort) state_d = IDLE;
                  else if (done_trans) state_d = COMB;
                  else if (wd_expired) state_d = ERROR;
         COMB:    if (abort) state_d = IDLE;
                  else if (done_comb) state_d = ARGMAX;
                  else if (wd_expired) state_d = ERROR;
         ARGMAX:  if (abort) state_d = IDLE;
                  else if (done_argmax) state_d = DONE;
                  else if (wd_expired) state_d = ERROR;
         DONE:    if (abort) state_d = IDLE;
                  else if (start) state_d = FLUSH;
         FLUSH:   state_d = TRANS;
         ERROR:   if (start) state_d = TRANS;
         default: state_d = IDLE;
      endcase
   end

   // The timed-out stage is captured on entry to ERROR and held while there.
   always_comb begin
      error_stage_d = STAGE_NONE;
      if (state_d == ERROR) begin
         error_stage_d = (state_q == ERROR) ? error_stage_q : stage_code(state_q);
      end
   end

   assign wd_clr = (state_d != state_q) && stage_active(state_d);

   gcn_stage_watchdog #(
      .TIMEOUT_CYCLES  (TIMEOUT_CYCLES),
      .STAGE_CNT_WIDTH (STAGE_CNT_WIDTH)
   ) u_watchdog (
      .clk       (clk),
      .reset     (reset),
      .clr_i     (wd_clr),
      .en_i      (stage_active(state_q)),
      .expired_o (wd_expired)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         en_trans_q    <= 1'b0;
         en_comb_q     <= 1'b0;
         en_argmax_q   <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         error_q       <= 1'b0;
         error_stage_q <= STAGE_NONE;
      end else begin
         state_q       <= state_d;
         en_trans_q    <= (state_d == TRANS) || (state_d == COMB) ||
                          (state_d == ARGMAX) || (state_d == DONE);
         en_comb_q     <= (state_d == COMB) || (state_d == ARGMAX) || (state_d == DONE);
         en_argmax_q   <= (state_d == ARGMAX) || (state_d == DONE);
         busy_q        <= stage_active(state_d);
         done_q        <= (state_d == DONE);
         error_q       <= (state_d == ERROR);
         error_stage_q <= error_stage_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cycle_q <= '0;
      end else if ((state_d == TRANS) && (state_q != TRANS)) begin
         cycle_q <= '0;
      end else if (stage_active(state_q) && (cycle_q != '1)) begin
         cycle_q <= cycle_q + CYCLE_WIDTH'(1);
      end
   end

   always_comb begin
      mem_rd_en   = 1'b0;
      mem_rd_addr = '0;
      case (state_q)
         TRANS: begin
            mem_rd_en   = trans_rd_en;
            mem_rd_addr = trans_rd_addr;
         end
         COMB: begin
            mem_rd_en   = comb_rd_en;
            mem_rd_addr = comb_rd_addr;
         end
         default: begin
            mem_rd_en   = 1'b0;
            mem_rd_addr = '0;
         end
      endcase
   end

   assign en_trans    = en_trans_q;
   assign en_comb     = en_comb_q;
   assign en_argmax   = en_argmax_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign error       = error_q;
   assign error_stage = error_stage_q;
   assign cycle_count = cycle_q;

endmodule

`default_nettype wire

// File: tb/tb_gcn_stage_sequencer.sv
// ============================================================================
// tb_gcn_stage_sequencer : directed vector table plus hand-written sequences
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_gcn_stage_sequencer;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0, abort = 1'b0;
   logic       done_trans = 1'b0, done_comb = 1'b0, done_argmax = 1'b0;
   logic       trans_rd_en = 1'b0, comb_rd_en = 1'b0;
   logic [7:0] trans_rd_addr = 8'h1A, comb_rd_addr = 8'h2B;

   logic        m_en_t, m_en_c, m_en_a, m_mem_en, m_busy, m_done, m_error;
   logic [7:0]  m_mem_addr;
   logic [1:0]  m_err_stage;
   logic [15:0] m_cycles;

   logic        w_en_t, w_en_c, w_en_a, w_mem_en, w_busy, w_done, w_error;
   logic [7:0]  w_mem_addr;
   logic [1:0]  w_err_stage;
   logic [15:0] w_cycles;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   gcn_stage_sequencer dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .done_trans(done_trans), .done_comb(done_comb), .done_argmax(done_argmax),
      .en_trans(m_en_t), .en_comb(m_en_c), .en_argmax(m_en_a),
      .trans_rd_en(trans_rd_en), .trans_rd_addr(trans_rd_addr),
      .comb_rd_en(comb_rd_en), .comb_rd_addr(comb_rd_addr),
      .mem_rd_en(m_mem_en), .mem_rd_addr(m_mem_addr),
      .busy(m_busy), .done(m_done), .error(m_error),
      .error_stage(m_err_stage), .cycle_count(m_cycles)
   );

   gcn_stage_sequencer #(.TIMEOUT_CYCLES(16)) dut_wd (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .done_trans(done_trans), .done_comb(done_comb), .done_argmax(done_argmax),
      .en_trans(w_en_t), .en_comb(w_en_c), .en_argmax(w_en_a),
      .trans_rd_en(trans_rd_en), .trans_rd_addr(trans_rd_addr),
      .comb_rd_en(comb_rd_en), .comb_rd_addr(comb_rd_addr),
      .mem_rd_en(w_mem_en), .mem_rd_addr(w_mem_addr),
      .busy(w_busy), .done(w_done), .error(w_error),
      .error_stage(w_err_stage), .cycle_count(w_cycles)
   );

   // in : {start, abort, done_trans, done_comb, done_argmax, trans_rd_en, comb_rd_en}
   // ex : {en_trans, en_comb, en_argmax, busy, done, error, mem_rd_en}
   typedef struct {
      logic [6:0] in;
      logic [6:0] ex;
      logic [7:0] addr;
   } vec_t;

   vec_t tbl [24];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      {start, abort, done_trans, done_comb, done_argmax} = '0;
      repeat (2) tick();
      reset = 1'b1;
   endtask

   initial begin
      tbl[0]  = '{7'b0000011, 7'b0000000, 8'h00};
      tbl[1]  = '{7'b1000011, 7'b1001001, 8'h1A};
      tbl[2]  = '{7'b1000011, 7'b1001001, 8'h1A};
      tbl[3]  = '{7'b0000001, 7'b1001000, 8'h1A};
      tbl[4]  = '{7'b0010011, 7'b1101001, 8'h2B};
      tbl[5]  = '{7'b1010010, 7'b1101000, 8'h2B};
      tbl[6]  = '{7'b0011011, 7'b1111000, 8'h00};
      tbl[7]  = '{7'b0011111, 7'b1110100, 8'h00};
      tbl[8]  = '{7'b0011111, 7'b1110100, 8'h00};
      tbl[9]  = '{7'b1011111, 7'b0000000, 8'h00};
      tbl[10] = '{7'b0100011, 7'b1001001, 8'h1A};
      tbl[11] = '{7'b0110011, 7'b0000000, 8'h00};
      tbl[12] = '{7'b0100011, 7'b0000000, 8'h00};
      tbl[13] = '{7'b1000011, 7'b1001001, 8'h1A};
      tbl[14] = '{7'b0010011, 7'b1101001, 8'h2B};
      tbl[15] = '{7'b0011011, 7'b1111000, 8'h00};
      tbl[16] = '{7'b0111111, 7'b0000000, 8'h00};
      tbl[17] = '{7'b1000011, 7'b1001001, 8'h1A};
      tbl[18] = '{7'b0010011, 7'b1101001, 8'h2B};
      tbl[19] = '{7'b0011011, 7'b1111000, 8'h00};
      tbl[20] = '{7'b0011111, 7'b1110100, 8'h00};
      tbl[21] = '{7'b1111111, 7'b0000000, 8'h00};
      tbl[22] = '{7'b0000011, 7'b0000000, 8'h00};
      tbl[23] = '{7'b1100011, 7'b1001001, 8'h1A};

      // Reset values, sampled while reset is still asserted
      reset = 1'b0;
      tick();
      chk("reset_main", {m_en_t, m_en_c, m_en_a, m_busy, m_done, m_error, m_mem_en,
                         m_err_stage, m_cycles}, 32'h0);
      chk("reset_wd", {w_en_t, w_en_c, w_en_a, w_busy, w_done, w_error, w_mem_en,
                       w_err_stage, w_cycles}, 32'h0);
      do_reset();

      // Table-driven single-cycle vectors
      for (int i = 0; i < 24; i++) begin
         {start, abort, done_trans, done_comb, done_argmax, trans_rd_en, comb_rd_en} = tbl[i].in;
         tick();
         chk($sformatf("vec%0d", i),
             {m_en_t, m_en_c, m_en_a, m_busy, m_done, m_error, m_mem_en, m_mem_addr},
             {tbl[i].ex, tbl[i].addr});
      end

      // Normal run: 10 / 20 / 6 cycles per stage
      do_reset();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("run_entry", {m_en_t, m_en_c, m_en_a, m_cycles}, {3'b100, 16'd0});
      for (int c = 1; c <= 40; c++) begin
         done_trans  = (c >= 10);
         done_comb   = (c >= 30);
         done_argmax = (c >= 36);
         tick();
         if (c == 9)  chk("run_c9",  {m_en_c, m_en_a}, 2'b00);
         if (c == 10) chk("run_c10", {m_en_t, m_en_c, m_en_a, m_cycles}, {3'b110, 16'd10});
         if (c == 30) chk("run_c30", {m_en_t, m_en_c, m_en_a, m_cycles}, {3'b111, 16'd30});
         if (c == 35) chk("run_c35", m_done, 1'b0);
         if (c == 36) chk("run_done", {m_done, m_busy, m_en_t, m_en_c, m_en_a, m_cycles},
                          {5'b10111, 16'd36});
         if (c == 40) chk("run_hold", {m_done, m_cycles}, {1'b1, 16'd36});
      end

      // Restart from DONE: one FLUSH cycle, then TRANS with a fresh count
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("flush", {m_en_t, m_en_c, m_en_a, m_done, m_busy, m_cycles}, {5'b00000, 16'd36});
      {done_trans, done_comb, done_argmax} = 3'b000;
      tick();
      chk("flush_to_trans", {m_en_t, m_en_c, m_busy, m_cycles}, {3'b101, 16'd0});
      tick();
      chk("restart_count", m_cycles, 32'd1);

      // Watchdog with TIMEOUT_CYCLES=16: Transformation timeout
      do_reset();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c <= 16; c++) begin
         tick();
         if (c == 15) chk("wd_t15", {w_error, w_en_t}, 2'b01);
         if (c == 16) chk("wd_trans", {w_error, w_err_stage, w_en_t, w_en_c, w_en_a, w_busy},
                          {1'b1, 2'd1, 4'b0000});
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("wd_abort_ignored", {w_error, w_err_stage}, {1'b1, 2'd1});
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("wd_restart", {w_error, w_err_stage, w_en_t}, {1'b0, 2'd0, 1'b1});

      // Combination timeout: ERROR 16 cycles after COMB entry
      done_trans = 1'b1;
      tick();
      chk("wd_comb_entry", w_en_c, 1'b1);
      for (int c = 1; c <= 16; c++) begin
         tick();
         if (c == 15) chk("wd_c15", {w_error, w_en_c}, 2'b01);
         if (c == 16) chk("wd_comb", {w_error, w_err_stage, w_en_t, w_en_c, w_en_a},
                          {1'b1, 2'd2, 3'b000});
      end
      done_trans = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("wd_clear", {w_error, w_err_stage, w_en_t}, {1'b0, 2'd0, 1'b1});

      // Done and expiry on the same edge: done wins
      done_trans = 1'b1;
      tick();
      done_comb = 1'b1;
      tick();
      for (int c = 1; c <= 16; c++) begin
         done_argmax = (c == 16);
         tick();
      end
      chk("wd_done_wins", {w_done, w_error, w_err_stage}, {1'b1, 1'b0, 2'd0});

      // Asynchronous reset mid-run, after a start pulsed while busy
      do_reset();
      start = 1'b1;
      tick();
      start = 1'b0;
      done_trans = 1'b1;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_busy_ignored", {m_en_t, m_en_c, m_en_a, m_busy, m_cycles},
          {4'b1101, 16'd2});
      #2;
      reset = 1'b0;
      #1;
      chk("async_reset", {m_en_t, m_en_c, m_en_a, m_busy, m_done, m_cycles},
          {5'b00000, 16'd0});
      #4;
      reset = 1'b1;
      done_trans = 1'b0;
      tick();
      chk("after_reset_idle", {m_en_t, m_busy}, 2'b00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
